// File: rtl/spu_pkg.sv
// Shared SPU types, sizes and the operand forwarding priority mux.
// Both the even and odd fetch stages use resolve_operand().
package spu_pkg;

    localparam int NUM_REGS = 128;
    localparam int FW_DEPTH = 7;
    localparam int WIDTH    = 128;

    typedef logic [0:6]   reg_addr_t;
    typedef logic [0:127] quad_t;
    typedef logic [0:10]  op_t;
    typedef logic [0:17]  imm_t;

    typedef enum logic [1:0] {
        UNIT_FP   = 2'd0,
        UNIT_FX2  = 2'd1,
        UNIT_BYTE = 2'd2,
        UNIT_FX1  = 2'd3
    } unit_e;

    typedef quad_t     [FW_DEPTH-1:0] fw_data_t;
    typedef reg_addr_t [FW_DEPTH-1:0] fw_addr_t;
    typedef logic      [FW_DEPTH-1:0] fw_en_t;

    // Sources are applied oldest-first so each later assignment overrides;
    // the final value is the youngest match. Index 0 is never a valid entry.
    function automatic quad_t resolve_operand(
        input reg_addr_t src,
        input fw_data_t  even_fw_data,
        input fw_addr_t  even_fw_addr,
        input fw_en_t    even_fw_en,
        input fw_data_t  odd_fw_data,
        input fw_addr_t  odd_fw_addr,
        input fw_en_t    odd_fw_en,
        input quad_t     even_wb_data,
        input reg_addr_t even_wb_addr,
        input logic      even_wb_en,
        input quad_t     odd_wb_data,
        input reg_addr_t odd_wb_addr,
        input logic      odd_wb_en,
        input quad_t     rf_data
    );
        quad_t res;
        res = rf_data;
        if (even_wb_en && (even_wb_addr == src)) res = even_wb_data;
        if (odd_wb_en  && (odd_wb_addr  == src)) res = odd_wb_data;
        for (int i = FW_DEPTH - 1; i >= 1; i--) begin
            if (even_fw_en[i] && (even_fw_addr[i] == src)) res = even_fw_data[i];
            if (odd_fw_en[i]  && (odd_fw_addr[i]  == src)) res = odd_fw_data[i];
        end
        return res;
    endfunction

endpackage

// File: rtl/spu_regfile.sv
// Architectural register file: two write ports (odd wins on collision),
// three asynchronous read ports, whole array cleared by synchronous reset.
module spu_regfile
    import spu_pkg::*;
#(
    parameter int N_REGS = 128,
    parameter int W      = 128
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [0:W-1]   even_wb_data,
    input  reg_addr_t      even_wb_addr,
    input  logic           even_wb_en,
    input  logic [0:W-1]   odd_wb_data,
    input  reg_addr_t      odd_wb_addr,
    input  logic           odd_wb_en,
    input  reg_addr_t      rd_addr_a,
    input  reg_addr_t      rd_addr_b,
    input  reg_addr_t      rd_addr_c,
    output logic [0:W-1]   rd_data_a,
    output logic [0:W-1]   rd_data_b,
    output logic [0:W-1]   rd_data_c
);

    logic [0:W-1] mem_q [N_REGS];

    // The odd write is issued last so it takes the slot when addresses collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (even_wb_en) mem_q[even_wb_addr] <= even_wb_data;
            if (odd_wb_en)  mem_q[odd_wb_addr]  <= odd_wb_data;
        end
    end

    assign rd_data_a = mem_q[rd_addr_a];
    assign rd_data_b = mem_q[rd_addr_b];
    assign rd_data_c = mem_q[rd_addr_c];

endmodule

// File: rtl/even_operand_fetch.sv
// Even-pipe RF/FWD stage: reads three sources, resolves them against both
// pipes' forwarding/writeback state and registers the operand bundle.
module even_operand_fetch #(
    parameter int NUM_REGS = 128,
    parameter int WIDTH    = 128,
    parameter int FW_DEPTH = 7
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    input  spu_pkg::op_t                        in_op,
    input  logic [2:0]                          in_format,
    input  logic [1:0]                          in_unit,
    input  spu_pkg::reg_addr_t                  in_rt_addr,
    input  spu_pkg::reg_addr_t                  in_ra_addr,
    input  spu_pkg::reg_addr_t                  in_rb_addr,
    input  spu_pkg::reg_addr_t                  in_rc_addr,
    input  spu_pkg::imm_t                       in_imm,
    input  logic                                in_reg_write,
    input  logic                                stall,
    input  logic                                branch_taken,
    input  logic [0:WIDTH-1]                    even_wb_data,
    input  spu_pkg::reg_addr_t                  even_wb_addr,
    input  logic                                even_wb_en,
    input  logic [0:WIDTH-1]                    odd_wb_data,
    input  spu_pkg::reg_addr_t                  odd_wb_addr,
    input  logic                                odd_wb_en,
    input  logic [FW_DEPTH-1:0][0:WIDTH-1]      even_fw_data,
    input  logic [FW_DEPTH-1:0][0:6]            even_fw_addr,
    input  logic [FW_DEPTH-1:0]                 even_fw_en,
    input  logic [FW_DEPTH-1:0][0:WIDTH-1]      odd_fw_data,
    input  logic [FW_DEPTH-1:0][0:6]            odd_fw_addr,
    input  logic [FW_DEPTH-1:0]                 odd_fw_en,
    output spu_pkg::op_t                        op,
    output logic [2:0]                          format,
    output logic [1:0]                          unit,
    output spu_pkg::reg_addr_t                  rt_addr,
    output spu_pkg::imm_t                       imm,
    output logic                                reg_write,
    output logic [0:WIDTH-1]                    ra,
    output logic [0:WIDTH-1]                    rb,
    output logic [0:WIDTH-1]                    rc
);

    logic [0:WIDTH-1] rf_ra, rf_rb, rf_rc;

    spu_regfile #(.N_REGS(NUM_REGS), .W(WIDTH)) u_regfile (
        .clk          (clk),
        .reset        (reset),
        .even_wb_data (even_wb_data),
        .even_wb_addr (even_wb_addr),
        .even_wb_en   (even_wb_en),
        .odd_wb_data  (odd_wb_data),
        .odd_wb_addr  (odd_wb_addr),
        .odd_wb_en    (odd_wb_en),
        .rd_addr_a    (in_ra_addr),
        .rd_addr_b    (in_rb_addr),
        .rd_addr_c    (in_rc_addr),
        .rd_data_a    (rf_ra),
        .rd_data_b    (rf_rb),
        .rd_data_c    (rf_rc)
    );

    // Slot 0 of each forwarding array never carries a valid result.
    logic unused_fw0;
    assign unused_fw0 = ^{even_fw_en[0], odd_fw_en[0], even_fw_addr[0], odd_fw_addr[0],
                          even_fw_data[0], odd_fw_data[0]};

    logic                bubble;
    spu_pkg::op_t        op_d, op_q;
    logic [2:0]          format_d, format_q;
    spu_pkg::unit_e      unit_d, unit_q;
    spu_pkg::reg_addr_t  rt_d, rt_q;
    spu_pkg::imm_t       imm_d, imm_q;
    logic                rw_d, rw_q;
    logic [0:WIDTH-1]    ra_d, ra_q, rb_d, rb_q, rc_d, rc_q;

    // A stalled instruction is not captured; it re-resolves when stall drops.
    assign bubble = stall | branch_taken | ~in_valid;

    always_comb begin
        op_d     = '0;
        format_d = '0;
        unit_d   = spu_pkg::UNIT_FP;
        rt_d     = '0;
        imm_d    = '0;
        rw_d     = 1'b0;
        ra_d     = '0;
        rb_d     = '0;
        rc_d     = '0;
        if (!bubble) begin
            op_d     = in_op;
            format_d = in_format;
            unit_d   = spu_pkg::unit_e'(in_unit);
            rt_d     = in_rt_addr;
            imm_d    = in_imm;
            rw_d     = in_reg_write;
            ra_d = spu_pkg::resolve_operand(in_ra_addr, even_fw_data, even_fw_addr, even_fw_en,
                odd_fw_data, odd_fw_addr, odd_fw_en, even_wb_data, even_wb_addr, even_wb_en,
                odd_wb_data, odd_wb_addr, odd_wb_en, rf_ra);
            rb_d = spu_pkg::resolve_operand(in_rb_addr, even_fw_data, even_fw_addr, even_fw_en,
                odd_fw_data, odd_fw_addr, odd_fw_en, even_wb_data, even_wb_addr, even_wb_en,
                odd_wb_data, odd_wb_addr, odd_wb_en, rf_rb);
            rc_d = spu_pkg::resolve_operand(in_rc_addr, even_fw_data, even_fw_addr, even_fw_en,
                odd_fw_data, odd_fw_addr, odd_fw_en, even_wb_data, even_wb_addr, even_wb_en,
                odd_wb_data, odd_wb_addr, odd_wb_en, rf_rc);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            format_q <= '0;
            unit_q   <= spu_pkg::UNIT_FP;
            rt_q     <= '0;
            imm_q    <= '0;
            rw_q     <= 1'b0;
            ra_q     <= '0;
            rb_q     <= '0;
            rc_q     <= '0;
        end else begin
            op_q     <= op_d;
            format_q <= format_d;
            unit_q   <= unit_d;
            rt_q     <= rt_d;
            imm_q    <= imm_d;
            rw_q     <= rw_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            rc_q     <= rc_d;
        end
    end

    assign op        = op_q;
    assign format    = format_q;
    assign unit      = unit_q;
    assign rt_addr   = rt_q;
    assign imm       = imm_q;
    assign reg_write = rw_q;
    assign ra        = ra_q;
    assign rb        = rb_q;
    assign rc        = rc_q;

endmodule

// File: tb/tb_even_operand_fetch.sv
// Randomised and directed checks of even_operand_fetch against a
// program-order search model of forwarding, writeback and register file.
module tb_even_operand_fetch;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  in_valid;
    logic [0:10]           in_op;
    logic [2:0]            in_format;
    logic [1:0]            in_unit;
    logic [0:6]            in_rt_addr, in_ra_addr, in_rb_addr, in_rc_addr;
    logic [0:17]           in_imm;
    logic                  in_reg_write, stall, branch_taken;
    logic [0:127]          even_wb_data, odd_wb_data;
    logic [0:6]            even_wb_addr, odd_wb_addr;
    logic                  even_wb_en, odd_wb_en;
    logic [6:0][0:127]     even_fw_data, odd_fw_data;
    logic [6:0][0:6]       even_fw_addr, odd_fw_addr;
    logic [6:0]            even_fw_en, odd_fw_en;
    logic [0:10]           op;
    logic [2:0]            format;
    logic [1:0]            unit;
    logic [0:6]            rt_addr;
    logic [0:17]           imm;
    logic                  reg_write;
    logic [0:127]          ra, rb, rc;

    even_operand_fetch dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op),
        .in_format(in_format), .in_unit(in_unit), .in_rt_addr(in_rt_addr),
        .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr), .in_rc_addr(in_rc_addr),
        .in_imm(in_imm), .in_reg_write(in_reg_write), .stall(stall),
        .branch_taken(branch_taken),
        .even_wb_data(even_wb_data), .even_wb_addr(even_wb_addr), .even_wb_en(even_wb_en),
        .odd_wb_data(odd_wb_data), .odd_wb_addr(odd_wb_addr), .odd_wb_en(odd_wb_en),
        .even_fw_data(even_fw_data), .even_fw_addr(even_fw_addr), .even_fw_en(even_fw_en),
        .odd_fw_data(odd_fw_data), .odd_fw_addr(odd_fw_addr), .odd_fw_en(odd_fw_en),
        .op(op), .format(format), .unit(unit), .rt_addr(rt_addr), .imm(imm),
        .reg_write(reg_write), .ra(ra), .rb(rb), .rc(rc)
    );

    // Clock
    always #5 clk = ~clk;

    typedef struct packed {
        logic [0:10]  op;
        logic [2:0]   fmt;
        logic [1:0]   unit;
        logic [0:6]   rt;
        logic [0:17]  imm;
        logic         rw;
        logic [0:127] ra;
        logic [0:127] rb;
        logic [0:127] rc;
    } bundle_t;

    bundle_t      exp_q[$];
    logic [0:127] rf_m [128];
    int           n_cmp  = 0;
    int           n_fail = 0;
    int           cyc    = 0;

    // Model: list every in-flight result youngest-first, first address hit wins.
    function automatic logic [0:127] model_src(input logic [0:6] a);
        logic [0:6]   ca[$];
        logic [0:127] cd[$];
        for (int i = 1; i < 7; i++) begin
            if (odd_fw_en[i])  begin ca.push_back(odd_fw_addr[i]);  cd.push_back(odd_fw_data[i]);  end
            if (even_fw_en[i]) begin ca.push_back(even_fw_addr[i]); cd.push_back(even_fw_data[i]); end
        end
        if (odd_wb_en)  begin ca.push_back(odd_wb_addr);  cd.push_back(odd_wb_data);  end
        if (even_wb_en) begin ca.push_back(even_wb_addr); cd.push_back(even_wb_data); end
        for (int k = 0; k < ca.size(); k++) begin
            if (ca[k] == a) return cd[k];
        end
        return rf_m[a];
    endfunction

    function automatic bundle_t model_out();
        bundle_t b;
        b = '0;
        if (!reset && in_valid && !stall && !branch_taken) begin
            b.op = in_op; b.fmt = in_format; b.unit = in_unit; b.rt = in_rt_addr;
            b.imm = in_imm; b.rw = in_reg_write;
            b.ra = model_src(in_ra_addr);
            b.rb = model_src(in_rb_addr);
            b.rc = model_src(in_rc_addr);
        end
        return b;
    endfunction

    function automatic logic [0:127] rand_quad();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Driver tasks
    task automatic clear_inputs();
        reset = 1'b0; in_valid = 1'b0; in_op = '0; in_format = '0; in_unit = '0;
        in_rt_addr = '0; in_ra_addr = '0; in_rb_addr = '0; in_rc_addr = '0;
        in_imm = '0; in_reg_write = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        even_wb_data = '0; even_wb_addr = '0; even_wb_en = 1'b0;
        odd_wb_data = '0; odd_wb_addr = '0; odd_wb_en = 1'b0;
        even_fw_data = '0; even_fw_addr = '0; even_fw_en = '0;
        odd_fw_data = '0; odd_fw_addr = '0; odd_fw_en = '0;
    endtask

    // One clock: predict the bundle for this edge, then update the model
    // register file, and return just after the compare at the next negedge.
    task automatic step();
        exp_q.push_back(model_out());
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 128; i++) rf_m[i] = '0;
        end else begin
            if (even_wb_en) rf_m[even_wb_addr] = even_wb_data;
            if (odd_wb_en)  rf_m[odd_wb_addr]  = odd_wb_data;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic check_lit(input string name, input logic [0:127] act, input logic [0:127] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard compare
    always @(negedge clk) begin
        bundle_t e, a;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{op, format, unit, rt_addr, imm, reg_write, ra, rb, rc};
            n_cmp++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL bundle cyc %0d: got op=%h fmt=%h unit=%h rt=%h imm=%h rw=%b ra=%h rb=%h rc=%h expected op=%h fmt=%h unit=%h rt=%h imm=%h rw=%b ra=%h rb=%h rc=%h",
                    cyc, a.op, a.fmt, a.unit, a.rt, a.imm, a.rw, a.ra, a.rb, a.rc,
                    e.op, e.fmt, e.unit, e.rt, e.imm, e.rw, e.ra, e.rb, e.rc);
            end
        end
    end

    initial begin
        logic [0:127] aa_q, five_q;
        aa_q   = {16{8'hAA}};
        five_q = {16{8'h55}};
        for (int i = 0; i < 128; i++) rf_m[i] = '0;
        clear_inputs();

        // Reset with an instruction and writebacks present: all must be ignored
        reset = 1'b1; in_valid = 1'b1; in_op = 11'h7FF; in_reg_write = 1'b1;
        even_wb_en = 1'b1; even_wb_addr = 7'd5; even_wb_data = rand_quad();
        step();
        check_lit("reset_op", {117'd0, op}, 128'd0);
        check_lit("reset_rw", {127'd0, reg_write}, 128'd0);
        step();
        check_lit("reset_ra", ra, 128'd0);

        clear_inputs();
        in_valid = 1'b1; in_ra_addr = 7'd5;
        step();
        check_lit("after_reset_ra5", ra, 128'd0);

        // Same-cycle writeback collision: odd data is stored
        clear_inputs();
        odd_wb_en = 1'b1; odd_wb_addr = 7'd10; odd_wb_data = aa_q;
        even_wb_en = 1'b1; even_wb_addr = 7'd10; even_wb_data = five_q;
        step();
        clear_inputs();
        in_valid = 1'b1; in_ra_addr = 7'd10;
        step();
        check_lit("wb_collision_ra", ra, aa_q);

        // Youngest forwarding entry wins over older entry and register file
        clear_inputs();
        even_wb_en = 1'b1; even_wb_addr = 7'd3; even_wb_data = 128'h1;
        step();
        clear_inputs();
        even_fw_en[4] = 1'b1; even_fw_addr[4] = 7'd3; even_fw_data[4] = 128'h2;
        odd_fw_en[2]  = 1'b1; odd_fw_addr[2]  = 7'd3; odd_fw_data[2]  = 128'h3;
        in_valid = 1'b1; in_ra_addr = 7'd3; in_rb_addr = 7'd3; in_rc_addr = 7'd3;
        step();
        check_lit("fw_youngest_ra", ra, 128'h3);
        check_lit("fw_youngest_rb", rb, 128'h3);
        check_lit("fw_youngest_rc", rc, 128'h3);

        // Odd beats even at the same index
        clear_inputs();
        even_fw_en[2] = 1'b1; even_fw_addr[2] = 7'd7; even_fw_data[2] = 128'h7E;
        odd_fw_en[2]  = 1'b1; odd_fw_addr[2]  = 7'd7; odd_fw_data[2]  = 128'h7F;
        in_valid = 1'b1; in_ra_addr = 7'd7;
        step();
        check_lit("fw_odd_over_even", ra, 128'h7F);

        // Stall for two cycles, forwarding appears late, then release
        clear_inputs();
        in_valid = 1'b1; in_ra_addr = 7'd9; in_op = 11'h123; stall = 1'b1;
        step();
        check_lit("stall1_op", {117'd0, op}, 128'd0);
        odd_fw_en[1] = 1'b1; odd_fw_addr[1] = 7'd9; odd_fw_data[1] = 128'h99;
        step();
        check_lit("stall2_ra", ra, 128'd0);
        stall = 1'b0;
        step();
        check_lit("stall_release_ra", ra, 128'h99);
        check_lit("stall_release_op", {117'd0, op}, 128'h123);

        // Branch flush, then a normal instruction
        clear_inputs();
        branch_taken = 1'b1; in_valid = 1'b1; in_reg_write = 1'b1; in_rt_addr = 7'd20;
        in_op = 11'h055;
        step();
        check_lit("flush_rw", {127'd0, reg_write}, 128'd0);
        check_lit("flush_op", {117'd0, op}, 128'd0);
        branch_taken = 1'b0;
        step();
        check_lit("post_flush_rw", {127'd0, reg_write}, 128'd1);
        check_lit("post_flush_rt", {121'd0, rt_addr}, 128'd20);

        // Stall together with branch gives one NOP
        stall = 1'b1; branch_taken = 1'b1;
        step();
        check_lit("stall_branch_op", {117'd0, op}, 128'd0);

        // Randomised traffic with occasional mid-stream reset
        for (int c = 0; c < 600; c++) begin
            reset        = ($urandom_range(0, 99) < 2);
            in_valid     = ($urandom_range(0, 9) < 8);
            stall        = ($urandom_range(0, 99) < 15);
            branch_taken = ($urandom_range(0, 99) < 10);
            in_op        = 11'($urandom());
            in_format    = 3'($urandom());
            in_unit      = 2'($urandom());
            in_imm       = 18'($urandom());
            in_reg_write = 1'($urandom());
            in_rt_addr   = 7'($urandom_range(0, 127));
            in_ra_addr   = ($urandom_range(0, 7) == 0) ? 7'd127 : 7'($urandom_range(0, 15));
            in_rb_addr   = 7'($urandom_range(0, 15));
            in_rc_addr   = 7'($urandom_range(0, 15));
            even_wb_en   = ($urandom_range(0, 9) < 4);
            even_wb_addr = ($urandom_range(0, 7) == 0) ? 7'd127 : 7'($urandom_range(0, 15));
            even_wb_data = rand_quad();
            odd_wb_en    = ($urandom_range(0, 9) < 4);
            odd_wb_addr  = 7'($urandom_range(0, 15));
            odd_wb_data  = rand_quad();
            even_fw_en   = '0;
            odd_fw_en    = '0;
            for (int i = 1; i < 7; i++) begin
                even_fw_en[i]   = ($urandom_range(0, 9) < 3);
                even_fw_addr[i] = 7'($urandom_range(0, 15));
                even_fw_data[i] = rand_quad();
                odd_fw_en[i]    = ($urandom_range(0, 9) < 3);
                odd_fw_addr[i]  = 7'($urandom_range(0, 15));
                odd_fw_data[i]  = rand_quad();
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/even_operand_fetch.md
# even_operand_fetch

Register-fetch/forward (RF/FWD) stage that feeds the even execution pipe. It accepts one decoded even-slot instruction per cycle and reads its three source operands from the architectural register file. Each operand is resolved against the in-flight results in both pipes' forwarding staging registers, and the block presents a registered operand bundle to the even pipe one cycle later. It also owns the 128×128 register file, including the two writeback ports from the even and odd pipes.

## Interface
Parameters:
- NUM_REGS, 128, architectural register count (address width 7)
- WIDTH, 128, register width in bits
- FW_DEPTH, 7, forwarding staging entries per pipe (index 0 always invalid)

Ports:
- clk  in  1  clock; one clock domain
- reset  in  1  synchronous, active-high
- in_valid  in  1  decoded instruction present this cycle
- in_op  in  11  decoded opcode [0:10]
- in_format  in  3  instruction format
- in_unit  in  2  even execution unit (0 FP, 1 FX2, 2 Byte, 3 FX1)
- in_rt_addr, in_ra_addr, in_rb_addr, in_rc_addr  in  7 each  destination and source addresses
- in_imm  in  18  immediate [0:17]
- in_reg_write  in  1  instruction writes rt
- stall  in  1  hazard stall from the dependency checker
- branch_taken  in  1  flush of younger instructions
- even_wb_data  in  128  even pipe writeback value
- even_wb_addr  in  7  even pipe writeback address
- even_wb_en  in  1  even pipe writeback enable
- odd_wb_data, odd_wb_addr, odd_wb_en  in  128/7/1  odd pipe writeback
- even_fw_data  in  FW_DEPTH×128  even forwarding values, index 1 youngest
- even_fw_addr  in  FW_DEPTH×7  even forwarding addresses
- even_fw_en  in  FW_DEPTH  even forwarding valid bits
- odd_fw_data, odd_fw_addr, odd_fw_en  in  same shapes  odd pipe forwarding
- op, format, unit, rt_addr, imm, reg_write  out  11/3/2/7/18/1  registered instruction fields to even pipe
- ra, rb, rc  out  128 each  resolved operand values

## Operation
- Each operand (ra, rb, rc) resolves independently. The first match in the following order wins:
  - Forwarding entries i = 1..FW_DEPTH-1 (youngest first); at each index, odd is checked before even because the odd slot is later in program order.
  - Odd writeback port, then even writeback port (same-cycle write-through bypass).
  - Register file contents.
- A forwarding or writeback entry matches only when its enable is 1 and its address equals the source address.
- Register file:
  - Written at posedge from both writeback ports when enabled.
  - If both ports target the same address in one cycle, the odd data is stored.
  - All 128 registers are writable.
- Bubble condition: stall=1, branch_taken=1, or in_valid=0. On a bubble the next output is a NOP: op=0, format=0, unit=0, rt_addr=0, imm=0, reg_write=0, ra=rb=rc=0.
- During a stall, upstream holds the instruction. It is re-resolved in the first non-stall cycle using the forwarding state of that cycle; operands are never captured during a stall.
- branch_taken has priority over in_valid. stall and branch_taken asserted together produce a single NOP.

## Timing
- Latency: inputs sampled at edge N, outputs valid from edge N to edge N+1 (1 cycle). Throughput is 1 instruction per cycle.
- Reset:
  - All outputs clear to 0 on the first edge with reset=1.
  - All NUM_REGS register-file entries clear to 0 over the reset cycle.
  - Writeback inputs are ignored while reset=1.
- Reset mid-stream: the in-flight instruction is dropped, the next output is a NOP, and the register file is cleared.
- A writeback at edge N is visible to an instruction sampled at the same edge N through the bypass, and through the register file from N+1 onward.
- Addresses are 7 bits wide; there is no wrap-around and no out-of-range case.

## Structure
- Shared package spu_pkg holds:
  - typedefs: reg_addr_t (logic[0:6]), quad_t (logic[0:127]), op_t (logic[0:10]), imm_t (logic[0:17])
  - constants: NUM_REGS, FW_DEPTH
  - unit enum: UNIT_FP, UNIT_FX2, UNIT_BYTE, UNIT_FX1
- Sub-module spu_regfile: 128×128 array with 2 write ports, 3 read ports and synchronous reset clear. The odd port wins on a write collision.
- The forwarding priority mux is a function in spu_pkg, resolve_operand(), so the odd-pipe fetch stage can reuse it.

## Test plan
- After reset, issue in_ra_addr=5 with no writes -> ra=0, and every output was 0 during reset.
- Write odd_wb reg 10=0xAA..AA and even_wb reg 10=0x55..55 in the same cycle, then read reg 10 -> ra=0xAA..AA.
- Register 3 in regfile=0x1, even_fw[4]=(3, 0x2), odd_fw[2]=(3, 0x3); ra=rb=rc=3 -> all three operands = 0x3.
- even_fw[2] and odd_fw[2] both target reg 7 with values 0x7E/0x7F -> ra=0x7F.
- Hold instruction (ra=9) with stall=1 for 2 cycles while odd_fw[1]=(9, 0x99) appears in the second cycle, then release stall -> NOP output during the stall, then ra=0x99 with the original op.
- branch_taken=1 with in_valid=1, in_reg_write=1, in_rt_addr=20 -> next output reg_write=0, op=0; the following valid instruction passes normally.
